fetch_unit: RTL

Instruction fetch stage directly upstream of `state_machine`: owns the program counter, prefetch buffer and instruction register, talks to instruction memory over a req/ack handshake, and presents `op` to the control FSM. It consumes `IRWrite`, `PCWrite` and `PCSource` from `state_machine` and produces `op`, plus a `Ready` flag that tells the control FSM a fetched instruction is waiting. Prefetch hides memory latency behind the previous instruction's execute cycles.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, one-entry prefetch buffer and
// instruction register, with a req/ack read port to instruction memory.
// The buffer refills while the control FSM executes the previous instruction.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic [1:0]  PCSource,
  input  logic [15:0] ALUResult,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [3:0]  op,
  output logic        Ready
);

  typedef enum logic [1:0] {StEmpty, StWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic        discard_q, discard_d;
  logic        req_q, ready_q;
  logic [15:0] pc_next;
  logic        flush;

  // Next PC; the jump target uses the IR as it stands before any same-cycle load.
  always_comb begin
    pc_next = pc_q;
    case (PCSource)
      2'd0: pc_next = pc_q + 16'd2;
      2'd1: pc_next = ALUResult;
      2'd2: pc_next = {pc_q[15:13], ir_q[11:0], 1'b0};
      2'd3: pc_next = pc_q;
    endcase
    pc_d  = PCWrite ? pc_next : pc_q;
    // Source 3 leaves the PC alone, so the prefetched word stays good.
    flush = PCWrite && (PCSource != 2'd3);
  end

  // Prefetch FSM next-state: launch, wait for ack (dropping stale data), hold.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    buf_d        = buf_q;
    fetch_addr_d = fetch_addr_q;
    discard_d    = discard_q;
    unique case (state_q)
      StEmpty: begin
        fetch_addr_d = pc_d;
        state_d      = StWait;
      end
      StWait: begin
        if (imem_ack) begin
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = StEmpty;
          end else begin
            buf_d   = imem_rdata;
            state_d = StFull;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      StFull: begin
        if (IRWrite) begin
          ir_d    = buf_q;
          state_d = StEmpty;
        end else if (flush) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and registered handshake/status outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= StEmpty;
      pc_q         <= RESET_PC;
      ir_q         <= 16'h0000;
      buf_q        <= 16'h0000;
      fetch_addr_q <= RESET_PC;
      discard_q    <= 1'b0;
      req_q        <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      buf_q        <= buf_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      req_q        <= (state_d == StWait);
      ready_q      <= (state_d == StFull);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_addr_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign op        = ir_q[15:12];
  assign Ready     = ready_q;

endmodule
